lc3b_alu_seq: RTL and testbench
===============================

// Module: lc3b_alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the LC-3b datapath ALU. Adds the LC-3b shift class
//  (LSHF/RSHFL/RSHFA) as an iterative 1-bit-per-cycle shifter, plus registered N/Z/P codes and
//  carry-out. Sits between register-file read and writeback; result is held until consumed.
// PARAMETERS
//  WIDTH    16                 datapath width in bits (>=4)
//  SHAMT_W  $clog2(WIDTH)      shift-amount width, taken from B[SHAMT_W-1:0]
// PORTS
//  clk        in   1       single clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  in_valid   in   1       operands/op presented
//  in_ready   out  1       block can accept this cycle
//  A          in   WIDTH   operand A (shift source)
//  B          in   WIDTH   operand B (shift amount in low SHAMT_W bits for shift ops)
//  ALUK       in   3       op code (see BEHAVIOUR)
//  out_valid  out  1       OUT/CC/COUT valid
//  out_ready  in   1       consumer takes result this cycle
//  OUT        out  WIDTH   registered result
//  CC         out  3       {N,Z,P} of OUT
//  COUT       out  1       carry-out of ADD; 0 for all other ops
//  busy       out  1       high in SHIFT state
// BEHAVIOUR
//  Ops: 0 ADD (A+B mod 2^WIDTH), 1 AND, 2 XOR, 3 PASSA, 4 LSHF, 5 RSHFL (zero fill),
//       6 RSHFA (sign fill from A[WIDTH-1]), 7 PASSB.
//  Reset (async, reset_n=0): state=IDLE, OUT=0, CC=3'b010, COUT=0, out_valid=0, busy=0.
//   Reset mid-shift aborts the op; no result is ever produced for it.
//  States: IDLE, SHIFT, DONE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  Accept of op 0-3,7, or shift with amount k=0: OUT/CC/COUT load at the accept edge;
//   next state DONE; out_valid=1 in the cycle after the accept edge (latency 1).
//  Accept of shift with k>0: work reg<=A, cnt<=k, op latched; next state SHIFT.
//   SHIFT: each edge shifts work reg 1 bit, cnt--; on the edge where cnt==1, OUT<=final
//   value, CC updated, state->DONE. out_valid rises k edges after the accept edge.
//   in_valid/A/B/ALUK ignored while in SHIFT.
//  DONE: out_valid=1; OUT/CC/COUT stable while out_ready=0 (no change, no drop).
//   out_ready=1 & in_valid=1 -> retire + accept same edge (back-to-back, no bubble).
//   out_ready=1 & in_valid=0 -> IDLE, out_valid=0.
//  CC: N=OUT[WIDTH-1]; Z=(OUT==0); P=~N&~Z; exactly one bit set. COUT only from ADD.
//  All outputs registered; no combinational path from inputs to OUT/CC/out_valid.
//   in_ready combinationally depends on out_ready only.
// STRUCTURE
//  Package lc3b_alu_pkg: ALUK code localparams (ALU_ADD..ALU_PASSB), state encoding
//   (ST_IDLE/ST_SHIFT/ST_DONE), CC reset constant CC_RESET=3'b010.
//  Sub-module lc3b_alu_core: purely combinational ops 0-3,7 plus COUT, WIDTH-parametrised.
//  Top holds FSM, shift work reg/counter, output/CC registers, handshake logic.
// TESTING (WIDTH=16)
//  ADD A=16'h7FFF B=16'h0001 -> OUT=16'h8000 CC=100 COUT=0, out_valid 1 cycle after accept.
//  ADD A=16'hFFFF B=16'h0001 -> OUT=0 CC=010 COUT=1; XOR 16'hAAAA^16'hAAAA -> OUT=0 CC=010.
//  RSHFA A=16'h8000 B=4 -> busy 4 cycles, in_ready=0 throughout, OUT=16'hF800 CC=100;
//   RSHFL same operands -> OUT=16'h0800 CC=001; LSHF A=16'h0001 B=15 -> 16'h8000.
//  LSHF A=16'h1234 B=0 -> OUT=16'h1234, latency 1, busy never asserted.
//  Backpressure: result ready, out_ready=0 for 3 cycles -> OUT/CC stable, in_ready=0; then
//   out_ready=1 with new AND 16'hF0F0&16'h0FF0 -> retire+accept same edge, next OUT=16'h00F0.
//  Reset_n pulsed low mid-way through RSHFL by 10 -> out_valid/busy drop immediately,
//   OUT=0 CC=010; after release, no stale result appears; next ADD 2+3 -> OUT=5 CC=001.

Source files
------------

// File: rtl/lc3b_alu_pkg.sv
// lc3b_alu_pkg: op codes, FSM encoding and reset constants shared by the LC-3b sequential ALU.
package lc3b_alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_AND   = 3'd1;
  localparam logic [2:0] ALU_XOR   = 3'd2;
  localparam logic [2:0] ALU_PASSA = 3'd3;
  localparam logic [2:0] ALU_LSHF  = 3'd4;
  localparam logic [2:0] ALU_RSHFL = 3'd5;
  localparam logic [2:0] ALU_RSHFA = 3'd6;
  localparam logic [2:0] ALU_PASSB = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] CC_RESET = 3'b010;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_LSHF) || (op == ALU_RSHFL) || (op == ALU_RSHFA);
  endfunction

endpackage

// File: rtl/lc3b_alu_core.sv
// lc3b_alu_core: single-cycle ops (ADD/AND/XOR/PASSA/PASSB) and ADD carry-out.
module lc3b_alu_core
  import lc3b_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       aluk_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    y_o = (aluk_i == ALU_ADD)   ? sum[WIDTH-1:0] :
          (aluk_i == ALU_AND)   ? (a_i & b_i) :
          (aluk_i == ALU_XOR)   ? (a_i ^ b_i) :
          (aluk_i == ALU_PASSB) ? b_i : a_i;
  end

  assign cout_o = (aluk_i == ALU_ADD) & sum[WIDTH];

endmodule

// File: rtl/lc3b_alu_seq.sv
// lc3b_alu_seq: handshaked LC-3b ALU with an iterative 1-bit-per-cycle shifter,
// registered result, N/Z/P codes and carry-out.
module lc3b_alu_seq
  import lc3b_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUK,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic [2:0]       CC,
  output logic             COUT,
  output logic             busy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [2:0]           cc_q, cc_d;
  logic                 cout_q, cout_d;
  logic [SHAMT_W-1:0]   k;
  logic                 accept, start_shift, last, load_now, core_cout;
  logic [WIDTH-1:0]     shifted, core_y;

  lc3b_alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (A),
    .b_i   (B),
    .aluk_i(ALUK),
    .y_o   (core_y),
    .cout_o(core_cout)
  );

  assign k           = B[SHAMT_W-1:0];
  assign accept      = in_valid & in_ready;
  assign start_shift = accept & is_shift(ALUK) & (k != '0);
  assign load_now    = accept & ~start_shift;
  assign last        = (state_q == ST_SHIFT) & (cnt_q == SHAMT_W'(1));
  // Arithmetic right shift replicates the MSB, which still holds A's sign bit.
  assign shifted     = (op_q == ALU_LSHF) ? {work_q[WIDTH-2:0], 1'b0}
                     : {(op_q == ALU_RSHFA) & work_q[WIDTH-1], work_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = accept                            ? (start_shift ? ST_SHIFT : ST_DONE) :
              (state_q == ST_SHIFT)             ? (last ? ST_DONE : ST_SHIFT) :
              (state_q == ST_DONE & ~out_ready) ? ST_DONE : ST_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT);
  end

  always_comb begin
    work_d = start_shift ? A : (state_q == ST_SHIFT) ? shifted : work_q;
    cnt_d  = start_shift ? k : (state_q == ST_SHIFT) ? cnt_q - SHAMT_W'(1) : cnt_q;
    op_d   = start_shift ? ALUK : op_q;
    out_d  = last ? shifted : load_now ? (is_shift(ALUK) ? A : core_y) : out_q;
    cout_d = last ? 1'b0 : load_now ? core_cout : cout_q;
    cc_d   = {out_d[WIDTH-1], out_d == '0, ~out_d[WIDTH-1] & (out_d != '0)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_ADD;
      out_q  <= '0;
      cc_q   <= CC_RESET;
      cout_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      out_q  <= out_d;
      cc_q   <= cc_d;
      cout_q <= cout_d;
    end
  end

  assign OUT  = out_q;
  assign CC   = cc_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_lc3b_alu_seq.sv
// tb_lc3b_alu_seq: table-driven and scoreboard-checked bench for lc3b_alu_seq (WIDTH=16).
module tb_lc3b_alu_seq;

  typedef struct packed {
    logic [15:0] out;
    logic [2:0]  cc;
    logic        cout;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [2:0]  ALUK = '0;
  logic        in_ready, out_valid, COUT, busy;
  logic [15:0] OUT;
  logic [2:0]  CC;

  res_t sbq[$];
  res_t mon_e;
  int   passed = 0;
  int   total = 0;
  vec_t tbl[14];

  lc3b_alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUK(ALUK), .out_valid(out_valid), .out_ready(out_ready),
    .OUT(OUT), .CC(CC), .COUT(COUT), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] o, input logic [2:0] cc, input logic co);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.exp.out = o; v.exp.cc = cc; v.exp.cout = co;
    return v;
  endfunction

  function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [16:0] s;
    int k;
    k = int'(b[3:0]);
    s = {1'b0, a} + {1'b0, b};
    r.cout = 1'b0;
    case (op)
      3'd0: begin r.out = s[15:0]; r.cout = s[16]; end
      3'd1: r.out = a & b;
      3'd2: r.out = a ^ b;
      3'd3: r.out = a;
      3'd4: r.out = a << k;
      3'd5: r.out = a >> k;
      3'd6: r.out = 16'($signed(a) >>> k);
      default: r.out = b;
    endcase
    r.cc = r.out[15] ? 3'b100 : (r.out == 16'h0) ? 3'b010 : 3'b001;
    return r;
  endfunction

  // Retire monitor: each negedge with out_valid & out_ready precedes exactly one retire edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: out_valid with empty scoreboard, OUT=%h CC=%b", OUT, CC);
      end else begin
        mon_e = sbq.pop_front();
        check("result", {12'h0, OUT, CC, COUT}, {12'h0, mon_e});
      end
    end
  end

  task automatic issue(input vec_t v);
    int n;
    ALUK = v.op; A = v.a; B = v.b; in_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      total++;
      $display("FAIL accept_timeout: in_ready=0 after 200 cycles, required 1");
    end else sbq.push_back(v.exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 500; n++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [18:0] snap;
    int n;
    logic bad;
    tbl[0]  = mkv(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0);
    tbl[1]  = mkv(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1'b1);
    tbl[2]  = mkv(3'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b010, 1'b0);
    tbl[3]  = mkv(3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 1'b0);
    tbl[4]  = mkv(3'd3, 16'h8001, 16'h1234, 16'h8001, 3'b100, 1'b0);
    tbl[5]  = mkv(3'd7, 16'h1234, 16'h0005, 16'h0005, 3'b001, 1'b0);
    tbl[6]  = mkv(3'd6, 16'h8000, 16'h0004, 16'hF800, 3'b100, 1'b0);
    tbl[7]  = mkv(3'd5, 16'h8000, 16'h0004, 16'h0800, 3'b001, 1'b0);
    tbl[8]  = mkv(3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b100, 1'b0);
    tbl[9]  = mkv(3'd4, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1'b0);
    tbl[10] = mkv(3'd6, 16'h7000, 16'h0003, 16'h0E00, 3'b001, 1'b0);
    tbl[11] = mkv(3'd0, 16'h1234, 16'h4321, 16'h5555, 3'b001, 1'b0);
    tbl[12] = mkv(3'd5, 16'hFFFF, 16'h00F1, 16'h7FFF, 3'b001, 1'b0);
    tbl[13] = mkv(3'd2, 16'h0F0F, 16'hF0F0, 16'hFFFF, 3'b100, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", OUT, 16'h0);
    check("rst_cc", CC, 3'b010);
    check("rst_cout", COUT, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) issue(tbl[i]);
    drain();

    issue(mkv(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0));
    check("add_latency1_valid", out_valid, 1);
    drain();

    issue(mkv(3'd6, 16'h8000, 16'h0004, 16'hF800, 3'b100, 1'b0));
    n = 0; bad = 1'b0;
    while (busy && n < 50) begin
      if (in_ready) bad = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    check("rshfa_busy_cycles", n, 4);
    check("rshfa_in_ready_low", bad, 0);
    check("rshfa_valid_after_k", out_valid, 1);
    drain();

    issue(mkv(3'd4, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1'b0));
    check("lshf0_latency1_valid", out_valid, 1);
    check("lshf0_no_busy", busy, 0);
    drain();

    out_ready = 1'b0;
    issue(mkv(3'd2, 16'h0F0F, 16'hF0F0, 16'hFFFF, 3'b100, 1'b0));
    snap = {OUT, CC};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_value", {13'h0, OUT, CC}, {13'h0, snap});
      check("bp_in_ready_low", in_ready, 0);
      check("bp_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    issue(mkv(3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 1'b0));
    check("b2b_no_bubble", out_valid, 1);
    check("b2b_out", OUT, 16'h00F0);
    drain();

    issue(mkv(3'd5, 16'h8000, 16'h000A, 16'h0020, 3'b001, 1'b0));
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", OUT, 16'h0);
    check("mid_rst_cc", CC, 3'b010);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad = 1'b1;
    end
    check("no_stale_after_rst", bad, 0);
    issue(mkv(3'd0, 16'h0002, 16'h0003, 16'h0005, 3'b001, 1'b0));
    drain();

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.op = 3'($urandom_range(0, 7));
      v.a  = 16'($urandom);
      v.b  = 16'($urandom);
      v.exp = model(v.op, v.a, v.b);
      issue(v);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
